// File: rtl/gesture_model_acc_requant_24s_8s.sv
// Streaming accumulate-and-requantize stage: sums cfg_len signed products plus a bias, then
// applies a rounding arithmetic right shift and saturates to a signed OUT_WIDTH activation.
module gesture_model_acc_requant_24s_8s #(
  parameter int unsigned PROD_WIDTH = 24,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  input  logic [4:0]                   cfg_shift,
  input  logic signed [ACC_WIDTH-1:0]  cfg_bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  dout,
  output logic                         out_sat,
  output logic                         busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StRound, StHold} state_e;

  // One extra bit so the rounding add on a full-scale accumulator cannot overflow.
  localparam int unsigned RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] OutMax = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] OutMin = RW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  state_e                        state_q;
  logic [LEN_WIDTH-1:0]          len_q;
  logic [LEN_WIDTH-1:0]          cnt_q;
  logic [4:0]                    shift_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [OUT_WIDTH-1:0]   dout_q;
  logic                          sat_q;

  logic                          in_xfer;
  logic                          out_xfer;
  logic signed [ACC_WIDTH-1:0]   din_ext;
  logic [LEN_WIDTH-1:0]          first_len;
  logic [LEN_WIDTH-1:0]          cnt_inc;
  logic signed [RW-1:0]          acc_ext;
  logic signed [RW-1:0]          rnd_add;
  logic signed [RW-1:0]          sum_w;
  logic signed [RW-1:0]          r_w;
  logic                          r_hi;
  logic                          r_lo;
  logic signed [OUT_WIDTH-1:0]   clip_val;

  assign in_ready  = ce & ((state_q == StIdle) | (state_q == StAccum));
  assign out_valid = ce & (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign dout      = dout_q;
  assign out_sat   = sat_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  assign din_ext   = ACC_WIDTH'(din);
  assign first_len = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);

  // Round half up: add 2^(shift-1) before the arithmetic shift.
  assign acc_ext  = RW'(acc_q);
  assign rnd_add  = (shift_q == 5'd0) ? '0 : (RW'(1) << (shift_q - 5'd1));
  assign sum_w    = acc_ext + rnd_add;
  assign r_w      = sum_w >>> shift_q;
  assign r_hi     = (r_w > OutMax);
  assign r_lo     = (r_w < OutMin);
  assign clip_val = r_hi ? OutMax[OUT_WIDTH-1:0] :
                    r_lo ? OutMin[OUT_WIDTH-1:0] : r_w[OUT_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else if (ce) begin
      case (state_q)
        StIdle: begin
          if (in_xfer) begin
            len_q   <= first_len;
            shift_q <= cfg_shift;
            acc_q   <= cfg_bias + din_ext;
            cnt_q   <= LEN_WIDTH'(1);
            state_q <= (first_len == LEN_WIDTH'(1)) ? StRound : StAccum;
          end
        end
        StAccum: begin
          if (in_xfer) begin
            acc_q <= acc_q + din_ext;
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= StRound;
            end
          end
        end
        StRound: begin
          dout_q  <= clip_val;
          sat_q   <= r_hi | r_lo;
          state_q <= StHold;
        end
        StHold: begin
          if (out_xfer) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gesture_model_acc_requant_24s_8s.sv
// Self-checking bench for gesture_model_acc_requant_24s_8s: directed scenarios plus randomized
// transactions checked against an arithmetic reference model.
module tb_gesture_model_acc_requant_24s_8s;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic [9:0]         cfg_len;
  logic [4:0]         cfg_shift;
  logic signed [31:0] cfg_bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] din;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  dout;
  logic               out_sat;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;

  gesture_model_acc_requant_24s_8s dut (
    .clk       (clk),
    .reset     (rst_n),
    .ce        (ce),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision sum, wrapped to 32 bits, floor((acc + half) / 2^shift), clipped.
  function automatic void model(input int bias, input longint d[$], input int shift,
                                output int e, output bit sat);
    longint acc;
    longint r;
    acc = longint'(bias);
    foreach (d[i]) acc += d[i];
    acc = longint'(int'(acc));
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r = r >>> shift;
    sat = (r > 127) || (r < -128);
    e = (r > 127) ? 127 : (r < -128) ? -128 : int'(r);
  endfunction

  // Called and returns ~1ns after a falling edge; exactly one rising edge transfers the beat.
  task automatic send_beat(input logic signed [23:0] d);
    int w = 0;
    in_valid = 1'b1;
    din = d;
    #1;
    while (!in_ready && w < 100) begin
      @(negedge clk); #1; w++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end
    @(negedge clk);
    in_valid = 1'b0;
    din = '0;
    #1;
  endtask

  task automatic do_txn(input int len_cfg, input int shift, input int bias, input longint d[$],
                        input int gap_max, input int rdy_delay,
                        output logic signed [7:0] o, output logic s);
    int w;
    cfg_len = 10'(len_cfg);
    cfg_shift = 5'(shift);
    cfg_bias = bias;
    out_ready = 1'b0;
    foreach (d[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin @(negedge clk); #1; end
      send_beat(24'(d[i]));
    end
    repeat (rdy_delay) begin @(negedge clk); #1; end
    out_ready = 1'b1;
    #1;
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (!out_valid) begin
      n_checks++;
      $display("FAIL txn_timeout: out_valid=0 after %0d cycles, required 1", w);
    end
    o = dout;
    s = out_sat;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, expected 0", busy); else n_pass++;
    n_checks++; if (dout !== 8'sd0) $display("FAIL reset_dout: got %0d, expected 0", dout); else n_pass++;
    n_checks++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %0b, expected 0", out_sat); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_basic();
    int w = 0;
    cfg_len = 10'd4; cfg_shift = 5'd4; cfg_bias = 0;
    out_ready = 1'b1;
    send_beat(24'sd100);
    send_beat(24'sd200);
    send_beat(24'sd300);
    send_beat(24'sd400);
    // One cycle after the last transfer the block is rounding: not yet valid.
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_latency_round: out_valid got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL basic_round_in_ready: got %0b, expected 0", in_ready); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency_hold: out_valid got %0b, expected 1", out_valid); else n_pass++;
    n_checks++; if (dout !== 8'sd63) $display("FAIL basic_dout: got %0d, expected 63", dout); else n_pass++;
    n_checks++; if (out_sat !== 1'b0) $display("FAIL basic_sat: got %0b, expected 0", out_sat); else n_pass++;
    @(negedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_after: busy got %0b, expected 0", busy); else n_pass++;
  endtask

  task automatic test_pos_sat();
    longint d[$];
    logic signed [7:0] o;
    logic s;
    d = '{8388607, 8388607};
    do_txn(2, 8, 0, d, 0, 0, o, s);
    n_checks++; if (o !== 8'sd127) $display("FAIL pos_sat_dout: got %0d, expected 127", o); else n_pass++;
    n_checks++; if (s !== 1'b1) $display("FAIL pos_sat_flag: got %0b, expected 1", s); else n_pass++;
  endtask

  task automatic test_neg_sat_round();
    longint d[$];
    logic signed [7:0] o;
    logic s;
    d = '{0};
    do_txn(1, 4, -100000, d, 0, 0, o, s);
    n_checks++; if (o !== -8'sd128) $display("FAIL neg_sat_dout: got %0d, expected -128", o); else n_pass++;
    n_checks++; if (s !== 1'b1) $display("FAIL neg_sat_flag: got %0b, expected 1", s); else n_pass++;
    d = '{-8};
    do_txn(1, 4, 0, d, 0, 1, o, s);
    n_checks++; if (o !== 8'sd0) $display("FAIL round_m8: got %0d, expected 0", o); else n_pass++;
    n_checks++; if (s !== 1'b0) $display("FAIL round_m8_sat: got %0b, expected 0", s); else n_pass++;
    d = '{-9};
    do_txn(1, 4, 0, d, 0, 0, o, s);
    n_checks++; if (o !== -8'sd1) $display("FAIL round_m9: got %0d, expected -1", o); else n_pass++;
  endtask

  task automatic test_backpressure();
    cfg_len = 10'd3; cfg_shift = 5'd0; cfg_bias = 5;
    out_ready = 1'b0;
    send_beat(24'sd1);
    repeat (2) begin @(negedge clk); #1; end
    send_beat(24'sd2);
    ce = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL ce_in_ready: got %0b, expected 0", in_ready); else n_pass++;
    @(negedge clk); #1;
    ce = 1'b1;
    send_beat(24'sd3);
    @(negedge clk); #1;
    // Offer a beat while holding; it must not be taken.
    in_valid = 1'b1;
    din = 24'sd99;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %0b, expected 1", i, out_valid); else n_pass++;
      n_checks++; if (dout !== 8'sd11) $display("FAIL bp_dout[%0d]: got %0d, expected 11", i, dout); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %0b, expected 0", i, in_ready); else n_pass++;
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    din = '0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_single_xfer: out_valid got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_idle: busy got %0b, expected 0", busy); else n_pass++;
    n_checks++; if (dout !== 8'sd11) $display("FAIL bp_dout_kept: got %0d, expected 11", dout); else n_pass++;
  endtask

  task automatic test_len0_latch();
    longint d[$];
    logic signed [7:0] o;
    logic s;
    int w = 0;
    d = '{50};
    do_txn(0, 1, 0, d, 0, 0, o, s);
    n_checks++; if (o !== 8'sd25) $display("FAIL len0_dout: got %0d, expected 25", o); else n_pass++;
    cfg_len = 10'd3; cfg_shift = 5'd2; cfg_bias = 4;
    send_beat(24'sd10);
    cfg_len = 10'd1; cfg_shift = 5'd0; cfg_bias = 1000;
    send_beat(24'sd20);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL latch_still_accum: in_ready got %0b, expected 1", in_ready); else n_pass++;
    send_beat(24'sd30);
    out_ready = 1'b1;
    #1;
    while (!out_valid && w < 20) begin @(negedge clk); #1; w++; end
    n_checks++; if (dout !== 8'sd16) $display("FAIL latch_dout: got %0d, expected 16", dout); else n_pass++;
    @(negedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    longint d[$];
    logic signed [7:0] o;
    logic s;
    cfg_len = 10'd4; cfg_shift = 5'd0; cfg_bias = 0;
    send_beat(24'sd7);
    send_beat(24'sd9);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %0b, expected 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b, expected 0", out_valid); else n_pass++;
    n_checks++; if (dout !== 8'sd0) $display("FAIL rmid_dout: got %0d, expected 0", dout); else n_pass++;
    n_checks++; if (out_sat !== 1'b0) $display("FAIL rmid_sat: got %0b, expected 0", out_sat); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    d = '{10, 20};
    do_txn(2, 0, 0, d, 0, 0, o, s);
    n_checks++; if (o !== 8'sd30) $display("FAIL rmid_after: got %0d, expected 30", o); else n_pass++;
  endtask

  task automatic test_random();
    longint d[$];
    logic signed [7:0] o;
    logic s;
    logic signed [23:0] t;
    int len, nb, shift, bias, e;
    bit es;
    for (int n = 0; n < 30; n++) begin
      len = int'($urandom_range(6, 0));
      nb = (len == 0) ? 1 : len;
      shift = int'($urandom_range(31, 0));
      if ($urandom_range(1, 0) == 1) bias = int'($urandom);
      else bias = int'($urandom_range(2000, 0)) - 1000;
      d.delete();
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(1, 0) == 1) t = 24'($urandom);
        else t = 24'(int'($urandom_range(600, 0)) - 300);
        d.push_back(longint'(t));
      end
      model(bias, d, shift, e, es);
      do_txn(len, shift, bias, d, 2, int'($urandom_range(3, 0)), o, s);
      n_checks++; if (o !== 8'(e)) $display("FAIL rand_dout[%0d]: got %0d, expected %0d (len=%0d shift=%0d bias=%0d)", n, o, e, len, shift, bias); else n_pass++;
      n_checks++; if (s !== es) $display("FAIL rand_sat[%0d]: got %0b, expected %0b", n, s, es); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce = 1'b1;
    cfg_len = '0;
    cfg_shift = '0;
    cfg_bias = '0;
    in_valid = 1'b0;
    din = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat_round();
    test_backpressure();
    test_len0_latch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gesture_model_acc_requant_24s_8s.md
# gesture_model_acc_requant_24s_8s

Streaming accumulate-and-requantize stage that consumes the signed 24-bit products emitted by the gesture model's pipelined multipliers. It sums a configurable number of products plus a bias, then rescales the sum with a rounding arithmetic right shift. The result is saturated back to a signed 8-bit activation for the next layer. It sits between the multiplier array and the activation buffer and provides valid/ready flow control on both sides.

## Interface
Parameters:
- PROD_WIDTH, 24, signed product input width
- ACC_WIDTH, 32, signed accumulator width (≥ PROD_WIDTH)
- OUT_WIDTH, 8, signed output width
- LEN_WIDTH, 10, width of beat-count configuration

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset; asynchronous, active-low
- ce  in  1  clock enable; 0 freezes all state
- cfg_len  in  LEN_WIDTH  products per output; 0 treated as 1; latched on first beat
- cfg_shift  in  5  right-shift amount 0..31; latched on first beat
- cfg_bias  in  ACC_WIDTH  signed bias; added on first beat
- in_valid  in  1  din valid
- in_ready  out  1  block accepts din
- din  in  PROD_WIDTH  signed product
- out_valid  out  1  dout valid
- out_ready  in  1  downstream accepts dout
- dout  out  OUT_WIDTH  signed requantized result
- out_sat  out  1  dout was clipped, qualified by out_valid
- busy  out  1  state ≠ IDLE

## Operation
- Input transfer is in_valid & in_ready & ce; output transfer is out_valid & out_ready & ce.
- in_ready and out_valid are forced to 0 while ce=0.
- FSM states: IDLE, ACCUM, ROUND, HOLD.
- IDLE:
  - in_ready=1.
  - On an input transfer: latch len=max(cfg_len,1) and shift=cfg_shift; set acc ← cfg_bias + sext(din) and cnt ← 1.
  - Next state is ROUND if len=1, else ACCUM.
- ACCUM:
  - in_ready=1.
  - On an input transfer: acc ← acc + sext(din) and cnt ← cnt+1.
  - When the incoming beat makes cnt equal len, go to ROUND.
  - Without a transfer, hold state.
- ROUND:
  - in_ready=0; lasts 1 ce-cycle.
  - r = (acc + (shift>0 ? 2^(shift-1) : 0)) >>> shift, arithmetic, computed at ACC_WIDTH+1 bits so the rounding add cannot overflow.
  - dout ← clip(r, −2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1).
  - out_sat ← (r was outside that range). Go to HOLD.
- HOLD:
  - in_ready=0; out_valid=1; dout and out_sat stable.
  - On an output transfer, go to IDLE.
- The accumulator wraps modulo 2^ACC_WIDTH with no saturation inside the sum. Sizing ACC_WIDTH for cfg_len is the integrator's responsibility.
- Rounding is round-half-up toward +∞. For example, −8 with shift 4 gives 0, and −9 with shift 4 gives −1.
- cfg_* inputs are ignored except in IDLE on the first-beat transfer.

## Timing
- Reset (async assert, sync release on clk):
  - state=IDLE; acc=0; cnt=0.
  - dout=0; out_sat=0; out_valid=0; busy=0.
  - in_ready=1 once ce=1.
- Reset mid-accumulation discards the partial sum. No output is produced for those beats.
- Latency: if the last beat transfers at edge N, out_valid is high after edge N+1 (ROUND at N+1, HOLD visible from N+2 cycle). This assumes ce=1 throughout.
- Throughput: one result per len+2 cycles with out_ready=1. No input is accepted during ROUND or HOLD.
- ce=0 in any state stalls that state without loss; the ROUND computation is deferred.
- in_valid=0 gaps in ACCUM are allowed and do not affect the sum.
- out_ready may be high before out_valid. Transfer occurs on the first HOLD cycle.
- dout holds its last value after the transfer until the next ROUND.

## Test plan
- Basic sum:
  - Stimulus: len=4, bias=0, shift=4; din = 100, 200, 300, 400 back-to-back.
  - Required: acc=1000, result (1000+8)>>4 → dout=63, out_sat=0, out_valid 2 cycles after the 4th beat.
- Positive saturation:
  - Stimulus: len=2, bias=0, shift=8; din = 8388607, 8388607.
  - Required: r=65536 → dout=127, out_sat=1.
- Negative saturation and rounding:
  - Stimulus: len=1, bias=−100000, shift=4, din=0.
  - Required: r=−6250 → dout=−128, out_sat=1.
  - Then len=1, bias=0, shift=4, din=−8 → dout=0; din=−9 → dout=−1.
- Backpressure, gaps and ce:
  - Stimulus: len=3, bias=5, shift=0; din = 1, 2, 3 with a 2-cycle in_valid gap and one ce=0 cycle; out_ready low 5 cycles.
  - Required: dout=11 held stable, in_ready=0 throughout HOLD, one transfer when out_ready rises.
- len=0 and config latch:
  - Stimulus: cfg_len=0, din=50, shift=1.
  - Required: treated as len=1, dout=25. Changing cfg_* while in ACCUM does not alter the result.
- Reset mid-operation:
  - Stimulus: assert reset after 2 of 4 beats, release, then run len=2, din = 10, 20, shift=0.
  - Required: all outputs at reset values immediately on assertion; dout=30 with no residue from the aborted sum.
